// File: rtl/img_pkg.sv
// Shared definitions for the image read path: reader FSM states, default frame geometry,
// and a counter-width helper that stays legal for a range of 1.
package img_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  // Width needed to count 0..n-1; a one-value range still gets a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_frame_reader_if.sv
// Framed valid/ready pixel stream: data plus start-of-frame and end-of-line markers.
interface fifo_frame_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_sof;
  logic                  m_eol;

  modport master (output m_valid, output m_data, output m_sof, output m_eol, input m_ready);
  modport slave  (input m_valid, input m_data, input m_sof, input m_eol, output m_ready);
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready buffer; entry 0 is always the head so the output is a plain register.
module fifo_skid_buf #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] ent0;
  logic [DATA_WIDTH-1:0] ent1;
  logic                  pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = ent0;
  assign pop       = out_valid & out_ready;

  // The caller never pushes into a full buffer unless the head leaves in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      // NOTE: the data entries are reset too, so the stream data reads 0 after reset.
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      case ({in_valid, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= in_data;
          else               ent1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= in_data;
          end else begin
            ent0 <= ent1;
            ent1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_frame_reader.sv
// Read side of syn_fifo: pops exactly one IMG_W x IMG_H frame per start and emits it as a
// valid/ready pixel stream with start-of-frame and end-of-line markers.
module fifo_frame_reader
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   start,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_empty,
  fifo_frame_reader_if.master    m,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int XW    = cnt_w(IMG_W);
  localparam int YW    = cnt_w(IMG_H);
  localparam int PW    = $clog2(TOTAL + 1);

  rd_state_t             state;
  logic                  inflight;
  logic [1:0]            buf_count;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [PW-1:0]         pop_cnt;
  logic                  m_valid_i;
  logic [DATA_WIDTH-1:0] head;
  logic                  hs;
  logic                  x_last;
  logic                  y_last;
  logic [2:0]            occ;

  fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (inflight),
    .in_data  (fifo_rd_data),
    .out_valid(m_valid_i),
    .out_ready(m.m_ready),
    .out_data (head),
    .count    (buf_count)
  );

  assign hs     = m_valid_i & m.m_ready;
  assign x_last = (x == XW'(IMG_W - 1));
  assign y_last = (y == YW'(IMG_H - 1));

  // Occupancy after this cycle's handshake: counting the departing head lets a pop issue
  // every cycle under continuous ready while still never holding more than two pixels.
  assign occ        = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, hs};
  assign fifo_rd_en = (state == RUN) & ~fifo_empty & (occ < 3'd2);

  assign m.m_valid = m_valid_i;
  assign m.m_data  = head;
  assign m.m_sof   = m_valid_i & (x == '0) & (y == '0);
  assign m.m_eol   = m_valid_i & x_last;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      inflight   <= 1'b0;
      x          <= '0;
      y          <= '0;
      pop_cnt    <= '0;
    end else begin
      inflight   <= fifo_rd_en;
      frame_done <= 1'b0;
      if (fifo_rd_en) pop_cnt <= pop_cnt + PW'(1);

      if (hs) begin
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            pop_cnt <= '0;
          end
        end
        RUN: begin
          if (fifo_rd_en && pop_cnt == PW'(TOTAL - 1)) state <= DRAIN;
        end
        DRAIN: begin
          if (hs && x_last && y_last) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: a queue-based syn_fifo model feeds the DUT and every
// delivered pixel is compared against the words written into the FIFO, in write order.
module tb_fifo_frame_reader;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          start   = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty   = 1'b1;
  logic          busy;
  logic          frame_done;

  fifo_frame_reader_if #(.DATA_WIDTH(DW)) m_if ();

  fifo_frame_reader #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .m           (m_if.master),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- syn_fifo model and writer ----------------
  logic [DW-1:0] fq[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] exp_q[$];
  int cyc = 0, pops = 0, pops_base = 0, viol = 0;
  int wr_period = 0, wr_tick = 0;

  always @(posedge sys_clk) begin
    cyc++;
    if (fifo_rd_en) begin
      if (fq.size() == 0) viol++;
      else begin
        fifo_rd_data <= fq.pop_front();
        pops++;
      end
    end
    if (wr_period != 0 && wq.size() != 0) begin
      wr_tick++;
      if (wr_tick >= wr_period) begin
        wr_tick = 0;
        fq.push_back(wq.pop_front());
      end
    end
    fifo_empty <= (fq.size() == 0);
  end

  // ---------------- downstream ready ----------------
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  always @(posedge sys_clk) begin
    #1;
    case (rdy_mode)
      0:       m_if.m_ready = 1'b1;
      1:       m_if.m_ready = 1'($urandom_range(0, 1));
      default: m_if.m_ready = 1'b0;
    endcase
  end

  // ---------------- output monitor ----------------
  int idx = 0, first_hs_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  bit stalled_prev = 0;
  logic [DW-1:0] prev_data;
  logic prev_sof, prev_eol;

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      idx = 0;
      stalled_prev = 0;
    end else begin
      if (stalled_prev) begin
        check("hold_valid", m_if.m_valid, 1);
        check("hold_data", m_if.m_data, prev_data);
        check("hold_markers", {m_if.m_sof, m_if.m_eol}, {prev_sof, prev_eol});
      end
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) check("unexpected_pixel", 1, 0);
        else begin
          check("pixel_data", m_if.m_data, exp_q.pop_front());
          check("pixel_sof", m_if.m_sof, idx == 0);
          check("pixel_eol", m_if.m_eol, (idx % W) == W - 1);
        end
        if (idx == 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        idx++;
      end
      stalled_prev = m_if.m_valid && !m_if.m_ready;
      prev_data = m_if.m_data;
      prev_sof  = m_if.m_sof;
      prev_eol  = m_if.m_eol;
      if (frame_done) begin
        check("frame_pixels", idx, N);
        check("frame_pops", pops - pops_base, N);
        check("busy_at_done", busy, 0);
        pops_base = pops;
        idx = 0;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic load(input int n, input int base, input bit rnd);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? DW'($urandom_range(0, 65535)) : DW'(base + i);
      fq.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Returns in the cycle frame_done is high (one time unit after the edge).
  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (frame_done) seen = 1;
    end
    if (!seen) check({"timeout_", tag}, 0, 1);
  endtask

  task automatic wait_idx(input string tag, input int target, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (idx >= target) seen = 1;
    end
    if (!seen) check({"timeout_", tag}, 0, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t_pop, t_val;
    #23;
    check("reset_outputs", {fifo_rd_en, m_if.m_valid, m_if.m_sof, m_if.m_eol, busy, frame_done}, 0);
    check("reset_data", m_if.m_data, 0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    step(1);

    // 1: preloaded 2..13, continuous ready
    load(N, 2, 0);
    step(2);
    pulse_start();
    check("t1_busy", busy, 1);
    t_pop = -1;
    t_val = -1;
    for (int i = 0; i < 20 && t_val < 0; i++) begin
      if (t_pop < 0 && fifo_rd_en) t_pop = cyc;
      if (t_val < 0 && m_if.m_valid) t_val = cyc;
      if (t_val < 0) step(1);
    end
    check("t1_latency", t_val - t_pop, 2);
    wait_done("t1", 100);
    step(1);
    check("t1_span", last_hs_cyc - first_hs_cyc, N - 1);
    check("t1_done_gap", done_cyc - last_hs_cyc, 1);
    check("t1_busy_after", busy, 0);

    // 2: slow writer, one word every 3 clk
    for (int i = 0; i < N; i++) begin
      wq.push_back(DW'(16'h100 + i));
      exp_q.push_back(DW'(16'h100 + i));
    end
    wr_period = 3;
    pulse_start();
    wait_done("t2", 300);
    wr_period = 0;
    check("t2_no_pop_while_empty", viol, 0);
    step(2);

    // 3: random ready plus a 10-clk stall
    load(N, 0, 1);
    step(2);
    rdy_mode = 1;
    pulse_start();
    step(6);
    rdy_mode = 2;
    step(10);
    rdy_mode = 1;
    wait_done("t3", 500);
    rdy_mode = 0;
    step(2);

    // 4: 20 words in FIFO, one frame read leaves 8 for the next frame
    load(20, 0, 1);
    step(2);
    pulse_start();
    wait_done("t4a", 200);
    check("t4_fifo_left", fq.size(), 8);
    load(4, 0, 1);
    step(2);
    pulse_start();
    wait_done("t4b", 200);
    check("t4_fifo_empty", fq.size(), 0);
    step(2);

    // 5: start mid-frame is ignored; reset at pixel 6
    load(N, 0, 1);
    step(2);
    pulse_start();
    wait_idx("t5_px3", 3, 100);
    pulse_start();
    check("t5_busy_mid", busy, 1);
    wait_idx("t5_px6", 6, 100);
    #1 sys_rst = 1'b0;
    #1;
    check("t5_reset_outputs", {fifo_rd_en, m_if.m_valid, m_if.m_sof, m_if.m_eol, busy, frame_done}, 0);
    check("t5_reset_data", m_if.m_data, 0);
    step(2);
    sys_rst = 1'b1;
    pops_base = pops;
    exp_q.delete();
    foreach (fq[i]) exp_q.push_back(fq[i]);
    if (fq.size() < N) load(N - fq.size(), 0, 1);
    step(2);
    pulse_start();
    wait_done("t5", 200);
    step(2);

    // 6: start in the frame_done cycle is ignored
    load(N + 3, 0, 1);
    step(2);
    pulse_start();
    wait_done("t6", 200);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("t6_busy_next", busy, 0);
    step(5);
    check("t6_busy_later", busy, 0);
    check("t6_no_pop", fq.size(), 3);
    check("no_pop_while_empty", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
